// File: rtl/alu_scan_param.sv
// Two-stage ALU whose opcode, operand, result (and optional flag) registers form one scan chain.
// Define ALU_SCAN_FLAGS_EN to add carry/zero flag registers to the datapath and to the chain.
module alu_scan_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             scan_out,
  output logic             scan_done
);

`ifdef ALU_SCAN_FLAGS_EN
  localparam int F = 2;
`else
  localparam int F = 0;
`endif
  localparam int CHAIN_LEN = 3 + 3*WIDTH + F;
  localparam int CW        = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam int RES_LSB   = F;
  localparam int B_LSB     = F + WIDTH;
  localparam int A_LSB     = F + 2*WIDTH;
  localparam int OP_LSB    = F + 3*WIDTH;

  // Every architectural register lives in chain_q; the named fields are views of it.
  logic [CHAIN_LEN-1:0] chain_q;
  logic [CHAIN_LEN-1:0] func_next;
  logic [CW-1:0]        shift_cnt;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     res_q;
  logic [WIDTH-1:0]     alu_res;

  assign op_q  = chain_q[OP_LSB  +: 3];
  assign a_q   = chain_q[A_LSB   +: WIDTH];
  assign b_q   = chain_q[B_LSB   +: WIDTH];
  assign res_q = chain_q[RES_LSB +: WIDTH];

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = a_q - b_q;
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q | b_q;
      3'b100:  alu_res = a_q ^ b_q;
      3'b101:  alu_res = {a_q[WIDTH-2:0], 1'b0};
      3'b110:  alu_res = {1'b0, a_q[WIDTH-1:1]};
      default: alu_res = a_q;
    endcase
  end

`ifdef ALU_SCAN_FLAGS_EN
  logic cf_q;
  logic zf_q;
  logic alu_cf;

  // An unsigned add wrapped iff the truncated sum is smaller than an addend.
  always_comb begin
    alu_cf = 1'b0;
    case (op_q)
      3'b000:  alu_cf = (alu_res < a_q);
      3'b001:  alu_cf = (a_q < b_q);
      3'b101:  alu_cf = a_q[WIDTH-1];
      3'b110:  alu_cf = a_q[0];
      default: alu_cf = 1'b0;
    endcase
  end

  assign cf_q      = chain_q[1];
  assign zf_q      = chain_q[0];
  assign func_next = {op_code, A, B, alu_res, alu_cf, (alu_res == '0)};
  assign carry     = cf_q;
  assign zero      = zf_q;
`else
  assign func_next = {op_code, A, B, alu_res};
  assign carry     = 1'b0;
  assign zero      = 1'b0;
`endif

  // Shift mode freezes functional capture; leaving it resumes capture with the chain intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q   <= '0;
      shift_cnt <= '0;
      scan_done <= 1'b0;
    end else if (scan_en) begin
      chain_q   <= {scan_in, chain_q[CHAIN_LEN-1:1]};
      shift_cnt <= (shift_cnt == LAST) ? '0 : shift_cnt + 1'b1;
      scan_done <= (shift_cnt == LAST);
    end else begin
      chain_q   <= func_next;
      shift_cnt <= '0;
      scan_done <= 1'b0;
    end
  end

  assign result   = res_q;
  assign scan_out = chain_q[0];

endmodule

// File: tb/tb_alu_scan_param.sv
// Bench for alu_scan_param: fixed vectors, scan-chain sequences and random traffic against a reference model.
// Builds with or without ALU_SCAN_FLAGS_EN to match the design.
module tb_alu_scan_param;
  localparam int W = 4;
`ifdef ALU_SCAN_FLAGS_EN
  localparam int CL    = 3 + 3*W + 2;
  localparam int FB    = 2;
  localparam bit FLAGS = 1'b1;
`else
  localparam int CL    = 3 + 3*W;
  localparam int FB    = 0;
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         scan_en;
  logic         scan_in;
  logic [2:0]   op_code;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         scan_out;
  logic         scan_done;

  always #5 clk = ~clk;

  alu_scan_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .op_code(op_code), .A(a), .B(b),
    .result(result), .carry(carry), .zero(zero),
    .scan_out(scan_out), .scan_done(scan_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural fields plus a count of consecutive shift cycles.
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_cf, m_zf, m_done;
  int           m_run;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         cf, zf;
  } vec_t;
  vec_t tbl[12];

  function automatic void ref_alu(input int op, input int x, input int y, output int res, output int cf);
    int modv = 1 << W;
    case (op)
      0: begin res = (x + y) % modv; cf = int'((x + y) >= modv); end
      1: begin res = (x - y + modv) % modv; cf = int'(x < y); end
      2: begin res = x & y; cf = 0; end
      3: begin res = x | y; cf = 0; end
      4: begin res = x ^ y; cf = 0; end
      5: begin res = (x * 2) % modv; cf = int'(x >= modv / 2); end
      6: begin res = x / 2; cf = x % 2; end
      default: begin res = x; cf = 0; end
    endcase
  endfunction

  function automatic logic [CL-1:0] m_pack();
`ifdef ALU_SCAN_FLAGS_EN
    return {m_op, m_a, m_b, m_res, m_cf, m_zf};
`else
    return {m_op, m_a, m_b, m_res};
`endif
  endfunction

  task automatic m_unpack(input logic [CL-1:0] v);
`ifdef ALU_SCAN_FLAGS_EN
    {m_op, m_a, m_b, m_res, m_cf, m_zf} = v;
`else
    {m_op, m_a, m_b, m_res} = v;
`endif
  endtask

  task automatic model_edge();
    logic [CL-1:0] v;
    int r, c;
    if (rst) begin
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_cf = 1'b0; m_zf = 1'b0;
      m_run = 0; m_done = 1'b0;
    end else if (scan_en) begin
      v = m_pack();
      v = {scan_in, v[CL-1:1]};
      m_unpack(v);
      m_run++;
      m_done = (m_run % CL == 0);
    end else begin
      ref_alu(int'(m_op), int'(m_a), int'(m_b), r, c);
      m_res  = W'(r);
      m_cf   = FLAGS & (c != 0);
      m_zf   = FLAGS & (r == 0);
      m_op   = op_code;
      m_a    = a;
      m_b    = b;
      m_run  = 0;
      m_done = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [CL-1:0] v;
    v = m_pack();
    check("model_result",    32'(result),    32'(m_res));
    check("model_carry",     32'(carry),     32'(m_cf));
    check("model_zero",      32'(zero),      32'(m_zf));
    check("model_scan_out",  32'(scan_out),  32'(v[0]));
    check("model_scan_done", 32'(scan_done), 32'(m_done));
  endtask

  task automatic drive(input logic r, input logic se, input logic si,
                       input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    rst = r; scan_en = se; scan_in = si; op_code = op; a = x; b = y;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic shift(input logic si);
    drive(1'b0, 1'b1, si, 3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    tick();
  endtask

  initial begin
    logic [CL-1:0] tgt;
    logic [CL-1:0] got;
    logic [16:0]   pat_all;
    logic [W-1:0]  want;
    logic          se;

    tbl[0]  = '{3'b000, 4'b0011, 4'b0101, 4'b1000, 1'b0, 1'b0};
    tbl[1]  = '{3'b000, 4'b1001, 4'b0111, 4'b0000, 1'b1, 1'b1};
    tbl[2]  = '{3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0};
    tbl[3]  = '{3'b101, 4'b1001, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[4]  = '{3'b110, 4'b1001, 4'b0000, 4'b0100, 1'b1, 1'b0};
    tbl[5]  = '{3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
    tbl[6]  = '{3'b011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{3'b100, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{3'b111, 4'b0110, 4'b1001, 4'b0110, 1'b0, 1'b0};
    tbl[9]  = '{3'b001, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1};
    tbl[10] = '{3'b101, 4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0};
    tbl[11] = '{3'b110, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1};

    // Reset with random functional and scan inputs.
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    tick();
    check("reset_result",    32'(result),    32'h0);
    check("reset_carry",     32'(carry),     32'h0);
    check("reset_zero",      32'(zero),      32'h0);
    check("reset_scan_out",  32'(scan_out),  32'h0);
    check("reset_scan_done", 32'(scan_done), 32'h0);

    // Fixed vectors: two-cycle latency from inputs to result.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, tbl[i].op, tbl[i].a, tbl[i].b);
      exp_q.push_back(tbl[i].res);
      tick();
      tick();
      want = exp_q.pop_front();
      check("vec_result", 32'(result), 32'(want));
      check("vec_carry",  32'(carry),  32'(FLAGS & tbl[i].cf));
      check("vec_zero",   32'(zero),   32'(FLAGS & tbl[i].zf));
    end

    // Shift a pattern through the whole chain and read it back out.
    pat_all = 17'b1_0100_0111_0100_1101;
    for (int k = 0; k < CL; k++) begin
      shift(pat_all[k]);
      if (k < CL - 1) check("scan_done_early", 32'(scan_done), 32'h0);
    end
    check("scan_done_first", 32'(scan_done), 32'h1);
    for (int k = 0; k < CL; k++) begin
      check("scan_out_pattern", 32'(scan_out), 32'(pat_all[k]));
      shift(1'b0);
    end
    check("scan_done_second", 32'(scan_done), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
    tick();
    check("scan_done_func", 32'(scan_done), 32'h0);

    // Load operands by scan, capture once, then unload and inspect the fields.
`ifdef ALU_SCAN_FLAGS_EN
    tgt = {3'b000, 4'b0011, 4'b0101, 4'b0000, 2'b11};
`else
    tgt = {3'b000, 4'b0011, 4'b0101, 4'b0000};
`endif
    for (int k = 0; k < CL; k++) shift(tgt[k]);
    drive(1'b0, 1'b0, 1'b0, 3'b111, 4'b1010, 4'b0001);
    tick();
    check("capture_result", 32'(result), 32'h8);
    check("capture_carry",  32'(carry),  32'h0);
    check("capture_zero",   32'(zero),   32'h0);
    for (int k = 0; k < CL; k++) begin
      got[k] = scan_out;
      shift(1'b0);
    end
    check("unload_res", 32'(got[FB +: W]),          32'h8);
    check("unload_b",   32'(got[FB + W +: W]),      32'h1);
    check("unload_a",   32'(got[FB + 2*W +: W]),    32'hA);
    check("unload_op",  32'(got[FB + 3*W +: 3]),    32'h7);
`ifdef ALU_SCAN_FLAGS_EN
    check("unload_cf",  32'(got[1]), 32'h0);
    check("unload_zf",  32'(got[0]), 32'h0);
`endif

    // Reset in the middle of a shift sequence.
    drive(1'b0, 1'b0, 1'b0, 3'b000, 4'b1111, 4'b1111);
    tick();
    tick();
    for (int k = 0; k < 5; k++) shift(1'b1);
    drive(1'b1, 1'b1, 1'b1, 3'b000, '0, '0);
    tick();
    check("midshift_rst_result", 32'(result),    32'h0);
    check("midshift_rst_done",   32'(scan_done), 32'h0);
    for (int k = 0; k < CL; k++) begin
      check("midshift_rst_chain", 32'(scan_out), 32'h0);
      shift(1'b0);
      if (k < CL - 1) check("midshift_rst_done_early", 32'(scan_done), 32'h0);
    end
    check("midshift_rst_done_full", 32'(scan_done), 32'h1);

    // Random traffic with sticky scan_en so full and partial chains both occur.
    se = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) se = ~se;
      drive(1'($urandom_range(0, 40) == 0), se, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_scan_param.md
ALU_SCAN_PARAM -- requirements
Module: alu_scan_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width (>=2).
REQ-002 SHALL have localparam CHAIN_LEN = 3 + 3*WIDTH + F, where F=2 with ALU_SCAN_FLAGS_EN defined, else 0.
REQ-003 clk  input  1  single clock; all flops update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scan_en  input  1  1 = shift mode, 0 = functional mode.
REQ-006 scan_in  input  1  serial scan data in.
REQ-007 op_code  input  3  operation select.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 result  output  WIDTH  registered ALU result (res_q).
REQ-011 carry  output  1  registered carry/borrow/shift-out flag (cf_q).
REQ-012 zero  output  1  registered zero flag (zf_q).
REQ-013 scan_out  output  1  serial scan data out, = chain bit C[0].
REQ-014 scan_done  output  1  registered one-cycle pulse, full chain shifted.

Function
REQ-015 Chain vector C[CHAIN_LEN-1:0] SHALL be {op_q, a_q, b_q, res_q, cf_q, zf_q}, MSB first (cf_q/zf_q only with flags).
REQ-016 Functional mode: each cycle op_q/a_q/b_q <= op_code/A/B; res_q/flags <= f(op_q,a_q,b_q); input-to-result latency 2 cycles, throughput 1/cycle.
REQ-017 Ops: 000 ADD {cf,res}=a+b; 001 SUB res=a-b, cf=(a<b); 010 AND; 011 OR; 100 XOR; 101 SHL res=a<<1, cf=a[W-1]; 110 SHR logical res=a>>1, cf=a[0]; 111 PASS res=a.
REQ-018 cf SHALL be 0 for AND/OR/XOR/PASS; zf SHALL be 1 iff res==0 for every op.
REQ-019 Shift mode: each cycle C <= {scan_in, C[CHAIN_LEN-1:1]}; no functional capture; first bit shifted in reaches scan_out after CHAIN_LEN shifts.
REQ-020 shift_cnt SHALL increment per shift-mode cycle; on the cycle it equals CHAIN_LEN-1, it wraps to 0 and scan_done pulses high the next cycle.
REQ-021 shift_cnt SHALL clear to 0 whenever scan_en=0; scan_done SHALL be 0 in functional mode.
REQ-022 scan_en toggling mid-chain SHALL not corrupt C: deassert freezes shifting, next functional cycle captures normally.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-024 rst=1 at a rising edge SHALL clear all chain flops, shift_cnt and scan_done; result=0, carry=0, zero=0, scan_out=0.
REQ-025 rst SHALL take priority over scan_en, including mid-shift.
REQ-026 zero SHALL read 0 (not 1) immediately after reset until first functional capture of res.

Configuration
REQ-027 Macro ALU_SCAN_FLAGS_EN defined: cf_q/zf_q exist, are in chain, drive carry/zero; CHAIN_LEN=3+3*WIDTH+2.
REQ-028 Macro undefined: no flag flops, carry=zero=0 constant, CHAIN_LEN=3+3*WIDTH, scan_out=res_q[0].

Verification (WIDTH=4, flags enabled, CHAIN_LEN=17)
REQ-029 rst=1 one cycle with random inputs -> result=0000, carry=0, zero=0, scan_out=0, scan_done=0.
REQ-030 op=000 A=0011 B=0101 -> 2 cycles later result=1000 cf=0 zf=0; op=000 A=1001 B=0111 -> result=0000 cf=1 zf=1.
REQ-031 op=001 A=0011 B=0101 -> result=1110 cf=1; op=101 A=1001 -> result=0010 cf=1; op=110 A=1001 -> result=0100 cf=1.
REQ-032 scan_en=1, shift 17-bit pattern 1,0,1,1,0,0,1,0,1,1,1,0,0,0,1,0,1 -> scan_done high one cycle after 17th shift; 17 more shifts with scan_in=0 -> scan_out reproduces pattern in same order, scan_done pulses again.
REQ-033 Shift pattern loading op_q=000 a_q=0011 b_q=0101, drop scan_en one cycle, re-shift -> captured res_q field=1000, cf=0, zf=0.
REQ-034 rst=1 after 5 shifts -> chain all 0, shift_cnt 0, next 17 shifts required before scan_done.
